// File: rtl/cpu_run_control_if.sv
// CAR-side connection of cpu_run_control: boundary/halt from the current control
// word in, run/step/halt controls and the instruction count out.
interface cpu_run_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_instr_boundary;
  logic             i_halt;
  logic             o_cpu_start;
  logic             o_step_execution;
  logic             o_next_instr_stimulus;
  logic             o_halted;
  logic [CNT_W-1:0] o_instr_count;

  modport master (
    output i_instr_boundary, i_halt,
    input  o_cpu_start, o_step_execution, o_next_instr_stimulus, o_halted, o_instr_count
  );

  modport slave (
    input  i_instr_boundary, i_halt,
    output o_cpu_start, o_step_execution, o_next_instr_stimulus, o_halted, o_instr_count
  );
endinterface

// File: rtl/cpu_run_control.sv
// Start/step/halt run control for a microprogrammed CPU's control address register.
// Build option: define RUN_CTRL_DEBOUNCE_EN to debounce raw inputs over DB_CYCLES samples.
module cpu_run_control #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_start,
  input  logic             i_btn_step,
  input  logic             i_sw_step_mode,
  cpu_run_control_if.slave car
);
  localparam int NCH      = 3;
  localparam int CH_START = 0;
  localparam int CH_STEP  = 1;
  localparam int CH_MODE  = 2;

  logic [NCH-1:0] raw_s;
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] db_lvl_s;
  logic           mode_nxt_s;
  logic [1:0]     db_prev_q;
  logic [1:0]     rise_s;

  assign raw_s = {i_sw_step_mode, i_btn_step, i_btn_start};

  // two-flop synchronizer on every raw input
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= {NCH{1'b0}};
      sync2_q <= {NCH{1'b0}};
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

`ifdef RUN_CTRL_DEBOUNCE_EN
  localparam int unsigned     DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [NCH-1:0]  db_q;
  logic [NCH-1:0]  db_d;
  logic [DB_W-1:0] cnt_q [NCH];
  logic [DB_W-1:0] cnt_d [NCH];

  // stability counters: any sample matching the current level restarts the count
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      db_d[k]  = db_q[k];
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] == db_q[k]) begin
        cnt_d[k] = {DB_W{1'b0}};
      end else if (cnt_q[k] == DB_LAST) begin
        db_d[k]  = sync2_q[k];
        cnt_d[k] = {DB_W{1'b0}};
      end else begin
        cnt_d[k] = cnt_q[k] + DB_W'(1'b1);
      end
    end
  end

  // debounced level and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      db_q <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= {DB_W{1'b0}};
      end
    end else begin
      db_q <= db_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign db_lvl_s   = db_q;
  assign mode_nxt_s = db_d[CH_MODE];
`else
  logic unused_db_cycles_s;
  assign unused_db_cycles_s = (DB_CYCLES == 32'd0);
  assign db_lvl_s           = sync2_q;
  assign mode_nxt_s         = sync1_q[CH_MODE];
`endif

  // previous debounced button levels for 0->1 edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      db_prev_q <= 2'b00;
    end else begin
      db_prev_q <= db_lvl_s[1:0];
    end
  end

  assign rise_s = db_lvl_s[1:0] & ~db_prev_q;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e           state_q;
  logic             cpu_start_q;
  logic             halted_q;
  logic             pend_q;
  logic [CNT_W-1:0] count_q;
  logic             start_pulse_s;
  logic             step_pulse_s;
  logic             mode_s;
  logic             halt_evt_s;
  logic             count_en_s;

  assign start_pulse_s = rise_s[CH_START];
  assign step_pulse_s  = rise_s[CH_STEP];
  assign mode_s        = db_lvl_s[CH_MODE];
  assign halt_evt_s    = (state_q == ST_RUN) && car.i_halt && car.i_instr_boundary;
  // a pending step is consumed by this boundary; a fresh step pulse is not
  assign count_en_s    = (state_q == ST_RUN) && car.i_instr_boundary && !car.i_halt &&
                         (!mode_s || pend_q) && (count_q != {CNT_W{1'b1}});

  // run-state sequencing with registered CAR controls, step flag and instruction counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cpu_start_q <= 1'b0;
      halted_q    <= 1'b0;
      pend_q      <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse_s) begin
            state_q     <= ST_RUN;
            cpu_start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_evt_s) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q     <= ST_IDLE;
          cpu_start_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase

      if ((state_q != ST_RUN) || halt_evt_s || !mode_nxt_s) begin
        pend_q <= 1'b0;
      end else if (pend_q && car.i_instr_boundary) begin
        pend_q <= 1'b0;
      end else if (!pend_q && step_pulse_s && mode_s) begin
        pend_q <= 1'b1;
      end

      if (count_en_s) begin
        count_q <= count_q + CNT_W'(1'b1);
      end
    end
  end

  assign car.o_cpu_start           = cpu_start_q;
  assign car.o_step_execution      = mode_s;
  assign car.o_next_instr_stimulus = pend_q;
  assign car.o_halted              = halted_q;
  assign car.o_instr_count         = count_q;
endmodule

// File: tb/tb_cpu_run_control.sv
// Scoreboard bench for cpu_run_control (DB_CYCLES=4, CNT_W=4); expectations adapt to
// whether RUN_CTRL_DEBOUNCE_EN is defined.
module tb_cpu_run_control;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DB_CYCLES = 4;
`ifdef RUN_CTRL_DEBOUNCE_EN
  localparam int START_LAT = 7;
`else
  localparam int START_LAT = 3;
`endif

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic btn_start = 1'b0;
  logic btn_step  = 1'b0;
  logic sw_mode   = 1'b0;

  always #5 clk = ~clk;

  cpu_run_control_if #(.CNT_W(CNT_W)) car_if ();

  cpu_run_control #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_btn_start    (btn_start),
    .i_btn_step     (btn_step),
    .i_sw_step_mode (sw_mode),
    .car            (car_if)
  );

  typedef enum int {OB_START, OB_STEP, OB_STIM, OB_HALT, OB_COUNT, OB_LAT} obs_e;
  typedef struct {
    string tag;
    obs_e  sel;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   lat_meas = 0;
  int   exp_cnt  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] obs_val(input obs_e sel);
    case (sel)
      OB_START: obs_val = {31'd0, car_if.o_cpu_start};
      OB_STEP:  obs_val = {31'd0, car_if.o_step_execution};
      OB_STIM:  obs_val = {31'd0, car_if.o_next_instr_stimulus};
      OB_HALT:  obs_val = {31'd0, car_if.o_halted};
      OB_COUNT: obs_val = 32'(car_if.o_instr_count);
      OB_LAT:   obs_val = 32'(lat_meas);
      default:  obs_val = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic sb_push(input string tag, input obs_e sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_eq(e.tag, obs_val(e.sel), 32'(e.val));
    end
  endtask

  task automatic exp_all(input string pfx, input int st, input int sm, input int rq,
                         input int hl, input int cn);
    sb_push({pfx, "_start"}, OB_START, st);
    sb_push({pfx, "_mode"},  OB_STEP,  sm);
    sb_push({pfx, "_stim"},  OB_STIM,  rq);
    sb_push({pfx, "_halt"},  OB_HALT,  hl);
    sb_push({pfx, "_count"}, OB_COUNT, cn);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_step();
    btn_step = 1'b1;
    tick(8);
    btn_step = 1'b0;
    tick(8);
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    tick(10);
    btn_start = 1'b0;
    tick(12);
  endtask

  // one boundary pulse; exp_cnt follows the saturating count when the boundary should count
  task automatic boundary(input bit counts);
    car_if.i_instr_boundary = 1'b1;
    tick(1);
    car_if.i_instr_boundary = 1'b0;
    if (counts && exp_cnt < 15) exp_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    car_if.i_instr_boundary = 1'b0;
    car_if.i_halt           = 1'b0;
    rst_n = 1'b0;
    exp_all("rst", 0, 0, 0, 0, 0);
    tick(2);
    sb_drain();
    rst_n = 1'b1;
    tick(1);

`ifdef RUN_CTRL_DEBOUNCE_EN
    btn_start = 1'b1;
    sb_push("glitch_start", OB_START, 0);
    tick(3);
    btn_start = 1'b0;
    tick(12);
    sb_drain();
`endif

    btn_start = 1'b1;
    sb_push("start_lat", OB_LAT, START_LAT);
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (car_if.o_cpu_start === 1'b1) begin
        lat_meas = n;
        break;
      end
    end
    sb_drain();
    tick(10 - START_LAT);
    btn_start = 1'b0;
    tick(12);
    exp_all("run", 1, 0, 0, 0, 0);
    sb_drain();

    for (int i = 0; i < 5; i++) begin
      boundary(1'b1);
      sb_push("auto_stim", OB_STIM, 0);
      tick(1);
      sb_drain();
    end
    sb_push("auto_cnt", OB_COUNT, exp_cnt);
    sb_drain();

    sw_mode = 1'b1;
    sb_push("mode_on", OB_STEP, 1);
    tick(12);
    sb_drain();
    press_step();
    sb_push("step_req", OB_STIM, 1);
    sb_push("step_nocnt", OB_COUNT, exp_cnt);
    sb_drain();
    press_step();
    sb_push("step_drop_hold", OB_STIM, 1);
    sb_drain();
    boundary(1'b1);
    sb_push("step_clr", OB_STIM, 0);
    sb_push("step_cnt", OB_COUNT, exp_cnt);
    sb_drain();
    tick(3);
    sb_push("step_dropped", OB_STIM, 0);
    sb_drain();
    boundary(1'b0);
    tick(1);
    sb_push("step_idle_bnd", OB_COUNT, exp_cnt);
    sb_drain();

    press_step();
    sb_push("fall_pre", OB_STIM, 1);
    sb_drain();
    sw_mode = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick(1);
      sb_push("fall_mode", OB_STEP, (n < START_LAT - 1) ? 1 : 0);
      sb_push("fall_stim", OB_STIM, (n < START_LAT - 1) ? 1 : 0);
      sb_drain();
    end

    sw_mode = 1'b1;
    tick(12);
    press_step();
    sb_push("halt_pre", OB_STIM, 1);
    sb_drain();
    car_if.i_halt = 1'b1;
    exp_all("halt", 1, 1, 0, 1, exp_cnt);
    boundary(1'b0);
    car_if.i_halt = 1'b0;
    sb_drain();
    press_start();
    press_step();
    boundary(1'b0);
    tick(1);
    exp_all("halt_hold", 1, 1, 0, 1, exp_cnt);
    sb_drain();

    sw_mode = 1'b0;
    rst_n = 1'b0;
    exp_all("rst_halt", 0, 0, 0, 0, 0);
    tick(1);
    sb_drain();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick(12);
    press_start();
    sb_push("restart", OB_START, 1);
    sb_drain();
    for (int i = 0; i < 17; i++) begin
      boundary(1'b1);
      tick(1);
    end
    sb_push("sat_cnt", OB_COUNT, exp_cnt);
    sb_drain();

    sw_mode = 1'b1;
    tick(12);
    press_step();
    sb_push("rst_pre", OB_STIM, 1);
    sb_drain();
    sw_mode = 1'b0;
    rst_n = 1'b0;
    exp_all("rst_pend", 0, 0, 0, 0, 0);
    tick(1);
    sb_drain();
    rst_n = 1'b1;
    tick(2);
    exp_all("post_rst", 0, 0, 0, 0, 0);
    sb_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cpu_run_control.md
CPU_RUN_CONTROL -- requirements
Module: cpu_run_control

Interface
REQ-001 The block SHALL have a single clock, i_clk, and a synchronous active-low reset, i_rst_n, sampled on the rising edge of i_clk.
REQ-002 The block SHALL have parameter DB_CYCLES, default 50000: the number of consecutive stable synchronized samples needed to accept a new debounced level.
REQ-003 The block SHALL have parameter CNT_W, default 16: the width of the instruction counter.
REQ-004 The block SHALL have these ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_btn_start  in  1  raw start pushbutton, asynchronous
- i_btn_step  in  1  raw step pushbutton, asynchronous
- i_sw_step_mode  in  1  raw step-mode switch, asynchronous; 1 = step-by-step
- i_instr_boundary  in  1  high when the CAR sequencing field of the current control word is 2'b11
- i_halt  in  1  halt control bit C23 of the current control word
- o_cpu_start  out  1  CPU running enable to CAR
- o_step_execution  out  1  step mode to CAR
- o_next_instr_stimulus  out  1  step request to CAR
- o_halted  out  1  halt reached
- o_instr_count  out  CNT_W  count of completed instruction fetch returns

Function
REQ-005 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-006 The debounced level SHALL change only after DB_CYCLES consecutive synchronized samples differ from the current debounced level.
- Any sample equal to the current level SHALL clear the stability counter.
REQ-007 Button presses SHALL be detected as a debounced 0->1 edge, producing a one-cycle internal pulse.
REQ-008 The FSM SHALL have states IDLE, RUN and HALTED, with these transitions:
- IDLE -> RUN on a start pulse.
- RUN -> HALTED when i_halt && i_instr_boundary is sampled high.
- HALTED is left only through reset; start and step pulses are ignored in HALTED.
REQ-009 o_cpu_start SHALL be registered: 0 in IDLE, 1 in RUN and 1 in HALTED, so the CAR holds its value.
REQ-010 o_halted SHALL be registered and equal 1 only in HALTED.
REQ-011 o_step_execution SHALL equal the registered debounced switch level in all states.
REQ-012 Step handling SHALL use a pending flag:
- The flag sets on a step pulse while in RUN, o_step_execution=1 and the flag clear.
- Presses while the flag is set are dropped, not queued.
- o_next_instr_stimulus SHALL equal the flag.
- The flag clears on the cycle after i_instr_boundary is sampled high while set.
- The flag clears immediately when o_step_execution falls or the FSM enters HALTED.
REQ-013 A step pulse while o_step_execution=0, or in IDLE, SHALL have no effect.
REQ-014 o_instr_count SHALL increment by 1 on each cycle where all of these hold:
- the FSM is in RUN;
- i_instr_boundary=1 and i_halt=0;
- o_step_execution=0, or the pending flag is 1.
REQ-015 o_instr_count SHALL saturate at all-ones and not wrap.
REQ-016 If the step pulse and the boundary coincide with the flag clear, the flag SHALL set, and that boundary SHALL NOT count or consume it.
REQ-017 If i_halt && i_instr_boundary coincides with a pending step, HALTED SHALL take priority: the flag clears and no count is made.

Reset
REQ-018 While i_rst_n=0 at a clock edge, the block SHALL set:
- FSM = IDLE;
- all outputs = 0, o_instr_count = 0;
- synchronizers, debounced levels, stability counters and the pending flag = 0.
REQ-019 A reset asserted mid-operation, including in HALTED or with a step pending, SHALL take effect on the next edge with no residual pulse.

Configuration
REQ-020 Macro RUN_CTRL_DEBOUNCE_EN SHALL select the debounce behaviour:
- Defined: the debounce counters of REQ-006 are compiled in.
- Undefined: the counters are omitted, the debounced level equals the synchronizer output, and DB_CYCLES is ignored.
- All other behaviour is identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios, with RUN_CTRL_DEBOUNCE_EN defined and DB_CYCLES=4:
- Start debounce: i_btn_start high for 3 cycles then low -> o_cpu_start stays 0. Start held high 10 cycles -> o_cpu_start=1 exactly 2+4+1 cycles after the rise.
- Auto run: in RUN with step mode 0, pulse i_instr_boundary 5 times -> o_instr_count=5, o_next_instr_stimulus stays 0.
- Step handshake: step mode 1 and a valid step press -> o_next_instr_stimulus=1 and held until one i_instr_boundary. It clears the next cycle; the count increments by 1. A second press while pending is dropped.
- Halt: i_halt=1 with i_instr_boundary=1 in RUN -> o_halted=1 and o_cpu_start=1 next cycle; the count is unchanged; later start and step presses have no effect.
- Saturation and reset: with CNT_W=4, 17 boundaries -> o_instr_count=4'hF. Then i_rst_n=0 for 1 cycle while pending -> all outputs 0 at the next edge.
- Macro off: with the macro undefined, a 1-cycle-wide start pulse -> o_cpu_start=1 three cycles after the pulse.
